// File: rtl/guitar_pkg.sv
// Shared types and constants for the note scoring path.
// Mode codes come from the mode controller.
package guitar_pkg;

  typedef enum logic [2:0] {
    M_IDLE   = 3'b000,
    M_EASY   = 3'b001,
    M_MED    = 3'b010,
    M_HARD   = 3'b011,
    M_PAUSE  = 3'b100,
    M_FINISH = 3'b101
  } mode_t;

  localparam int NUM_LANES  = 4;
  localparam int SCORE_MAX  = 15;
  localparam int STREAK_MAX = 15;

  function automatic logic [2:0] popcnt4(
    input logic [NUM_LANES-1:0] v
  );
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/note_scorer_lane_judge.sv
// One lane: hit window countdown, button edge detect and
// combinational hit/miss judgement for the current cycle.
module lane_judge
  import guitar_pkg::*;
#(
  parameter int WIN_W = 22
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             freeze,
  input  logic [WIN_W-1:0] load_val,
  input  logic             note_in,
  input  logic             button,
  output logic             hit,
  output logic             miss
);

  logic [WIN_W-1:0] r_win;
  logic             r_btn_q;
  logic [WIN_W-1:0] w_win_nxt;
  logic             w_edge;
  logic             w_open;
  logic             w_last;
  logic             w_active;

  always_comb begin
    w_open   = (r_win != '0);
    w_last   = (r_win == WIN_W'(1));
    w_edge   = button & ~r_btn_q;
    w_active = ~clear & ~freeze;

    hit  = w_active & w_edge & w_open;
    // Without an edge, an open note is lost on expiry or when overwritten.
    miss = w_active & (w_edge ? ~w_open
                              : (w_open & (note_in | w_last)));

    w_win_nxt = r_win;
    if (clear) begin
      w_win_nxt = '0;
    end else if (!freeze) begin
      if (note_in) begin
        w_win_nxt = load_val;
      end else if (w_edge && w_open) begin
        w_win_nxt = '0;
      end else if (w_open) begin
        w_win_nxt = r_win - WIN_W'(1);
      end
    end
  end

  // Button history keeps tracking while frozen so held buttons
  // do not produce a fresh edge on resume.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_win   <= '0;
      r_btn_q <= 1'b0;
    end else begin
      r_win   <= w_win_nxt;
      r_btn_q <= clear ? 1'b0 : button;
    end
  end

endmodule

// File: rtl/note_scorer.sv
// Four-lane note judge with score, streak and miss tracking.
// Score is held stable outside play for high-score sampling.
module note_scorer
  import guitar_pkg::*;
#(
  parameter int WIN_W      = 22,
  parameter int WIN_EASY   = 3_000_000,
  parameter int WIN_MED    = 1_800_000,
  parameter int WIN_HARD   = 900_000,
  parameter int MAX_MISSES = 3
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [2:0] mode,
  input  logic [3:0] note_in,
  input  logic [3:0] button,
  output logic [3:0] score,
  output logic [3:0] streak,
  output logic [1:0] miss_count,
  output logic       game_over,
  output logic [3:0] hit_flash
);

  localparam logic [WIN_W-1:0] L_EASY = WIN_W'(WIN_EASY);
  localparam logic [WIN_W-1:0] L_MED  = WIN_W'(WIN_MED);
  localparam logic [WIN_W-1:0] L_HARD = WIN_W'(WIN_HARD);
  localparam logic [1:0]       M_LIM  = 2'(MAX_MISSES);
  localparam logic [4:0]       K_MAX  = 5'(STREAK_MAX);
  localparam logic [5:0]       S_MAX  = 6'(SCORE_MAX);

  logic [3:0] r_score;
  logic [3:0] r_streak;
  logic [1:0] r_miss;
  logic [3:0] r_flash;

  logic             w_clear;
  logic             w_play;
  logic             w_freeze;
  logic [WIN_W-1:0] w_load;
  logic [3:0]       w_hit;
  logic [3:0]       w_miss;
  logic [2:0]       w_h;
  logic             w_m;
  logic [4:0]       w_k_sum;
  logic [3:0]       w_k_new;
  logic             w_bonus;
  logic [5:0]       w_s_sum;
  logic [3:0]       w_s_new;
  logic [2:0]       w_c_sum;
  logic [1:0]       w_c_new;
  logic             w_over;

  assign w_over = (r_miss == M_LIM);

  always_comb begin
    w_clear = 1'b0;
    w_play  = 1'b0;
    w_load  = '0;
    case (mode)
      M_IDLE: w_clear = 1'b1;
      M_EASY: begin
        w_play = 1'b1;
        w_load = L_EASY;
      end
      M_MED: begin
        w_play = 1'b1;
        w_load = L_MED;
      end
      M_HARD: begin
        w_play = 1'b1;
        w_load = L_HARD;
      end
      default: ;
    endcase
    // Game over acts like FINISH; IDLE still clears it.
    w_freeze = ~w_clear & (~w_play | w_over);
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_judge #(
      .WIN_W(WIN_W)
    ) u_lane (
      .clk      (clk),
      .n_rst    (n_rst),
      .clear    (w_clear),
      .freeze   (w_freeze),
      .load_val (w_load),
      .note_in  (note_in[g]),
      .button   (button[g]),
      .hit      (w_hit[g]),
      .miss     (w_miss[g])
    );
  end

  always_comb begin
    w_h     = popcnt4(w_hit);
    w_m     = |w_miss;
    w_k_sum = {1'b0, r_streak} + {2'b00, w_h};
    if (w_m) begin
      w_k_new = '0;
    end else if (w_k_sum > K_MAX) begin
      w_k_new = K_MAX[3:0];
    end else begin
      w_k_new = w_k_sum[3:0];
    end
    // Bonus point each time the streak crosses a multiple of four.
    w_bonus = ~w_m & (w_k_new[3:2] > r_streak[3:2]);
    w_s_sum = {2'b00, r_score} + {3'b000, w_h} + {5'b0, w_bonus};
    w_s_new = (w_s_sum > S_MAX) ? S_MAX[3:0] : w_s_sum[3:0];
    w_c_sum = {1'b0, r_miss} + {2'b00, w_m};
    w_c_new = (w_c_sum >= {1'b0, M_LIM}) ? M_LIM : w_c_sum[1:0];
  end

  always_ff @(posedge clk) begin
    if (!n_rst || w_clear) begin
      r_score  <= '0;
      r_streak <= '0;
      r_miss   <= '0;
      r_flash  <= '0;
    end else begin
      r_flash <= w_hit;
      if (!w_freeze) begin
        r_score  <= w_s_new;
        r_streak <= w_k_new;
        r_miss   <= w_c_new;
      end
    end
  end

  assign score      = r_score;
  assign streak     = r_streak;
  assign miss_count = r_miss;
  assign game_over  = w_over;
  assign hit_flash  = r_flash;

endmodule

// File: tb/tb_note_scorer.sv
// Directed bench for note_scorer: the driver queues the
// expected outputs per cycle, a monitor pops and compares.
module tb_note_scorer;
  import guitar_pkg::*;

  logic       clk;
  logic       n_rst;
  logic [2:0] mode;
  logic [3:0] note_in;
  logic [3:0] button;
  logic [3:0] score;
  logic [3:0] streak;
  logic [1:0] miss_count;
  logic       game_over;
  logic [3:0] hit_flash;

  typedef struct packed {
    logic [3:0] s;
    logic [3:0] k;
    logic [1:0] c;
    logic       g;
    logic [3:0] f;
  } exp_t;

  exp_t sb[$];
  exp_t e_pop;
  int   n_cmp;
  int   n_bad;
  int   n_cyc;

  logic [3:0] e_s, e_k, e_f;
  logic [1:0] e_c;
  logic       e_g;

  note_scorer #(
    .WIN_W     (22),
    .WIN_EASY  (8),
    .WIN_MED   (6),
    .WIN_HARD  (4),
    .MAX_MISSES(3)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .mode      (mode),
    .note_in   (note_in),
    .button    (button),
    .score     (score),
    .streak    (streak),
    .miss_count(miss_count),
    .game_over (game_over),
    .hit_flash (hit_flash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc %0d: got %0d expected %0d",
               nm, n_cyc, act, exp);
    end
  endtask

  // Monitor: outputs settle after posedge, checked 1 ns later.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e_pop = sb.pop_front();
      n_cyc++;
      chk("score", score, e_pop.s);
      chk("streak", streak, e_pop.k);
      chk("miss_count", {2'b00, miss_count}, {2'b00, e_pop.c});
      chk("game_over", {3'b000, game_over}, {3'b000, e_pop.g});
      chk("hit_flash", hit_flash, e_pop.f);
    end
  end

  task automatic clr();
    e_s = 0; e_k = 0; e_c = 0; e_g = 0; e_f = 0;
  endtask

  // Drive one cycle; expectation is the state after its posedge.
  task automatic tick(input logic [3:0] nt, input logic [3:0] bt);
    note_in = nt;
    button  = bt;
    sb.push_back('{s: e_s, k: e_k, c: e_c, g: e_g, f: e_f});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(4'h0, 4'h0);
  endtask

  task automatic press(input logic [3:0] m, input logic [3:0] s,
                       input logic [3:0] k);
    e_s = s; e_k = k; e_f = m;
    tick(4'h0, m);
    e_f = 4'h0;
    tick(4'h0, 4'h0);
  endtask

  task automatic hit(input logic [3:0] m, input logic [3:0] s,
                     input logic [3:0] k);
    e_f = 4'h0;
    tick(m, 4'h0);
    press(m, s, k);
  endtask

  task automatic stray(input logic [3:0] m, input logic [1:0] c,
                       input logic g);
    e_k = 0; e_c = c; e_g = g; e_f = 0;
    tick(4'h0, m);
    tick(4'h0, 4'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0; n_bad = 0; n_cyc = 0;
    n_rst = 1'b0; mode = M_IDLE;
    note_in = 0; button = 0;
    clr();
    @(negedge clk);
    idle(2);
    n_rst = 1'b1;
    mode  = M_EASY;

    // single hit three cycles after the note
    tick(4'b0001, 4'h0);
    idle(2);
    press(4'b0001, 1, 1);

    // unanswered note expires after 8 cycles
    tick(4'b0010, 4'h0);
    idle(7);
    e_k = 0; e_c = 1;
    tick(4'h0, 4'h0);

    mode = M_IDLE; clr(); tick(4'h0, 4'h0);
    mode = M_EASY;

    // streak bonus and a two-lane chord
    hit(4'b0001, 1, 1);
    hit(4'b0010, 2, 2);
    hit(4'b0100, 3, 3);
    hit(4'b1000, 5, 4);
    hit(4'b0101, 7, 6);

    // build score 14 / streak 3, then saturate
    hit(4'b0011, 10, 8);
    hit(4'b0001, 11, 9);
    stray(4'b1000, 1, 0);
    hit(4'b0001, 12, 1);
    hit(4'b0010, 13, 2);
    hit(4'b0100, 14, 3);
    hit(4'b0111, 15, 6);

    // three strays end the game; play then freezes
    mode = M_IDLE; clr(); tick(4'h0, 4'h0);
    mode = M_EASY;
    stray(4'b0001, 1, 0);
    stray(4'b0010, 2, 0);
    stray(4'b0100, 3, 1);
    tick(4'b1111, 4'h0);
    tick(4'h0, 4'b1111);
    tick(4'h0, 4'h0);
    mode = M_IDLE; clr(); tick(4'h0, 4'h0);

    // window frozen across pause (incl. code 111)
    mode = M_EASY;
    tick(4'b0001, 4'h0);
    idle(2);
    mode = M_PAUSE; idle(10);
    mode = 3'b111;  idle(10);
    mode = M_EASY;  idle(1);
    press(4'b0001, 1, 1);

    // FINISH holds the score and ignores play input
    mode = M_FINISH;
    tick(4'b0001, 4'h0);
    tick(4'h0, 4'b0001);
    idle(4);

    // last cycle of a MEDIUM window still hits
    mode = M_MED;
    tick(4'b0010, 4'h0);
    idle(5);
    press(4'b0010, 2, 2);

    // HARD window expiry
    mode = M_HARD;
    tick(4'b1000, 4'h0);
    idle(3);
    e_k = 0; e_c = 1;
    tick(4'h0, 4'h0);

    // note plus edge on a closed lane: miss, then window opens
    e_c = 2;
    tick(4'b0100, 4'b0100);
    tick(4'h0, 4'h0);
    press(4'b0100, 3, 1);

    // note on an open window: old note missed, game over
    tick(4'b0001, 4'h0);
    tick(4'h0, 4'h0);
    e_k = 0; e_c = 3; e_g = 1;
    tick(4'b0001, 4'h0);
    tick(4'h0, 4'b0001);
    tick(4'h0, 4'h0);

    // reset clears, and a mid-window reset counts no miss
    n_rst = 1'b0; clr(); tick(4'h0, 4'h0);
    n_rst = 1'b1;
    tick(4'b0010, 4'h0);
    idle(1);
    n_rst = 1'b0; tick(4'h0, 4'h0);
    n_rst = 1'b1;
    idle(8);

    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/note_scorer.md
Name: note_scorer

Overview:
- Upstream of the high-score tracker: judges player button presses against note arrivals on 4 lanes during play and produces the running 4-bit score that the high-score stage samples when mode reaches FINISH.
- Also produces the streak, the miss count, a game_over flag for the mode controller, and per-lane hit pulses for the display.

Parameters:
- WIN_W, 22, bit width of each lane's window counter.
- WIN_EASY, 3_000_000, hit window in clk cycles in EASY mode (250 ms at 12 MHz).
- WIN_MED, 1_800_000, hit window in clk cycles in MEDIUM mode.
- WIN_HARD, 900_000, hit window in clk cycles in HARD mode.
- MAX_MISSES, 3, miss count that asserts game_over (range 1..3).

Ports:
- clk  in  1  system clock, 12 MHz
- n_rst  in  1  synchronous active-low reset
- mode  in  3  game mode from the mode controller
- note_in  in  4  per-lane 1-cycle pulse: a note enters the strike zone
- button  in  4  per-lane debounced, synchronised button level
- score  out  4  running score, saturating at 15; feeds high-score stage
- streak  out  4  consecutive hits, saturating at 15
- miss_count  out  2  misses this game, saturating at MAX_MISSES
- game_over  out  1  level; high while miss_count == MAX_MISSES
- hit_flash  out  4  per-lane 1-cycle pulse on a judged hit

Behaviour:
- Reset (n_rst low at a posedge): score, streak, miss_count, hit_flash, game_over, all window counters and button history go to 0. Reset mid-window discards the pending note silently, with no miss counted.
- Mode encodings: IDLE 000, EASY 001, MEDIUM 010, HARD 011, PAUSE 100, FINISH 101. Codes 110 and 111 behave as PAUSE.
- IDLE: same clearing as reset, applied every cycle.
- PAUSE and FINISH: all registers hold, window counters freeze, note_in is ignored.
  - Button history still updates, so a button held across a pause does not generate an edge on resume.
  - In FINISH, score is stable for the downstream high-score sampling.
- Play modes are EASY, MEDIUM and HARD. When game_over is high, the block behaves as FINISH regardless of mode.
- Per lane, in play:
  - note_in=1 loads the window counter with the window length for the current mode.
  - An open window decrements by 1 each cycle.
  - A button rising edge (button=1 this cycle, 0 in the previous sampled cycle) while the window is nonzero is a hit. The window clears to 0.
  - The window reaching 0 from 1 without a hit is a miss.
  - A button rising edge with the window at 0 is a miss.
  - note_in while the window is still open: the old note counts as a miss and the window reloads.
  - note_in and a rising edge in the same cycle with the window at 0: the edge is judged first (miss), then the window loads.
- Latency: an event judged in cycle N updates outputs at the posedge ending cycle N. hit_flash is high for exactly cycle N+1.
- Per-cycle aggregation:
  - H = number of lanes hit this cycle (0..4).
  - M = 1 if any lane missed this cycle, otherwise 0.
  - If M=1: streak goes to 0. Otherwise streak = min(streak+H, 15).
  - Bonus: B=1 if M=0 and floor(new_streak/4) > floor(old_streak/4), otherwise 0.
  - score = min(score+H+B, 15). Compute in a 6-bit intermediate, then saturate.
  - miss_count = min(miss_count+M, MAX_MISSES). Multiple lane misses in one cycle count as 1.
- game_over is combinational from miss_count. It freezes all play in the cycle after the final miss.
- A mode change takes effect on the same cycle's judgement. A window open at a play→PAUSE transition resumes from its frozen value.

Decomposition:
- guitar_pkg:
  - mode_t enum with the six mode codes, including FINISH=3'b101.
  - NUM_LANES=4.
  - SCORE_MAX=15.
- Sub-module lane_judge, instantiated 4 times. It contains the window counter, button edge register, and hit/miss pulse generation.
  - Inputs: clk, n_rst, clear, freeze, load_val, note_in, button.
  - Outputs: hit, miss.
- The note_scorer top level holds the aggregation, saturation and the score, streak and miss registers.

Test Plan:
1. Use WIN_EASY=8 for simulation, mode=EASY. Pulse note_in[0], then press button[0] 3 cycles later -> hit_flash[0] pulses for 1 cycle, score=1, streak=1, miss_count=0.
2. Same setup, pulse note_in[1] and never press -> 8 cycles later miss_count=1, streak=0, score unchanged.
3. Four sequential hits -> at the 4th hit streak=4 and score=5 (bonus applied). Then hit lanes 0 and 2 in the same cycle -> streak=6, score=7.
4. Preload score=14, streak=3, then hit 3 lanes in one cycle -> score=15 (saturated), streak=6.
5. Three stray button edges with no notes -> miss_count=3, game_over=1. Further notes and presses leave all outputs unchanged. mode=IDLE -> everything returns to 0 next cycle.
6. Open a window, switch to PAUSE for 20 cycles, return to EASY, press within the remaining window -> hit is counted. In FINISH, score holds for ≥5 cycles. Pull n_rst low mid-window -> all outputs 0 and no miss is counted afterwards.
